// File: rtl/nvdla_package.sv
// Shared types for the NVDLA DBB request scheduler.
// Holds the FSM state encoding, the captured request bundle and defaults.
package nvdla_package;

    localparam int unsigned DBB_ADDR_W      = 64;
    localparam int unsigned DBB_LEN_W       = 4;
    localparam int unsigned DBB_ID_W        = 8;
    localparam int unsigned DBB_TIMEOUT_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } state_dbb_sched_t;

    typedef struct packed {
        logic [DBB_ADDR_W-1:0] addr;
        logic [DBB_LEN_W-1:0]  len;
        logic [DBB_ID_W-1:0]   id;
        logic                  write;
    } dbb_sched_req_t;

endpackage

// File: rtl/nvdla_rr_arb2.sv
// Two-way round-robin arbiter; index 0 wins ties when index 1 was granted last.
// The priority register only moves when upd_i accepts a grant.
module nvdla_rr_arb2 #(
    parameter logic RST_LAST = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic [1:0] gnt_o
);

    logic last_q;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= RST_LAST;
        end else if (upd_i && (|gnt_o)) begin
            last_q <= gnt_o[1];
        end
    end

endmodule

// File: rtl/nvdla_dbb_req_sched.sv
// Round-robin scheduler of DBB read/write requests onto a single-outstanding
// bridge, with completion watchdog, sticky error flags and saturating counters.
module nvdla_dbb_req_sched
    import nvdla_package::*;
#(
    parameter int unsigned ADDR_W      = DBB_ADDR_W,
    parameter int unsigned LEN_W       = DBB_LEN_W,
    parameter int unsigned ID_W        = DBB_ID_W,
    parameter int unsigned TIMEOUT_CYC = DBB_TIMEOUT_DEF,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              wr_req_valid_i,
    output logic              wr_req_ready_o,
    input  logic [ADDR_W-1:0] wr_req_addr_i,
    input  logic [LEN_W-1:0]  wr_req_len_i,
    input  logic [ID_W-1:0]   wr_req_id_i,
    input  logic              rd_req_valid_i,
    output logic              rd_req_ready_o,
    input  logic [ADDR_W-1:0] rd_req_addr_i,
    input  logic [LEN_W-1:0]  rd_req_len_i,
    input  logic [ID_W-1:0]   rd_req_id_i,
    output logic              br_req_valid_o,
    input  logic              br_req_ready_i,
    output logic              br_req_write_o,
    output logic [ADDR_W-1:0] br_req_addr_o,
    output logic [LEN_W-1:0]  br_req_len_o,
    output logic [ID_W-1:0]   br_req_id_o,
    input  logic              br_done_i,
    output logic              grant_write_o,
    output logic              busy_o,
    output logic              err_timeout_o,
    output logic              err_zero_len_o,
    input  logic              err_clear_i,
    output logic [CNT_W-1:0]  wr_cnt_o,
    output logic [CNT_W-1:0]  rd_cnt_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMR_MAX = TW'(TIMEOUT_CYC - 1);

    state_dbb_sched_t state_q, state_d;
    dbb_sched_req_t   req_q, req_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [1:0]       arb_req, gnt;
    logic             arb_upd;
    logic             cap;
    logic             zero_len;
    logic             done_hit;
    logic             to_hit;
    logic [LEN_W-1:0] gnt_len;

    assign arb_req = {wr_req_valid_i, rd_req_valid_i}
                   & {2{enable_i && (state_q == IDLE)}};

    nvdla_rr_arb2 #(
        .RST_LAST (1'b1)
    ) u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (arb_req),
        .upd_i (arb_upd),
        .gnt_o (gnt)
    );

    assign wr_req_ready_o = gnt[1];
    assign rd_req_ready_o = gnt[0];
    assign gnt_len        = gnt[1] ? wr_req_len_i : rd_req_len_i;

    always_comb begin
        req_d       = '0;
        req_d.write = gnt[1];
        req_d.len   = DBB_LEN_W'(gnt_len);
        req_d.addr  = DBB_ADDR_W'(gnt[1] ? wr_req_addr_i : rd_req_addr_i);
        req_d.id    = DBB_ID_W'(gnt[1] ? wr_req_id_i : rd_req_id_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        arb_upd  = 1'b0;
        cap      = 1'b0;
        zero_len = 1'b0;
        done_hit = 1'b0;
        to_hit   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|gnt) begin
                    arb_upd = 1'b1;
                    cap     = 1'b1;
                    if (gnt_len == '0) begin
                        zero_len = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (br_req_ready_i) begin
                    state_d = WAIT_DONE;
                    tmr_d   = '0;
                end
            end
            WAIT_DONE: begin
                tmr_d = tmr_q + 1'b1;
                // Completion takes precedence over an expiring watchdog.
                if (br_done_i) begin
                    done_hit = 1'b1;
                    state_d  = IDLE;
                end else if (tmr_q == TMR_MAX) begin
                    to_hit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q          <= '0;
            tmr_q          <= '0;
            err_timeout_o  <= 1'b0;
            err_zero_len_o <= 1'b0;
            wr_cnt_o       <= '0;
            rd_cnt_o       <= '0;
        end else begin
            tmr_q <= tmr_d;
            if (cap) begin
                req_q <= req_d;
            end
            if (to_hit) begin
                err_timeout_o <= 1'b1;
            end else if (err_clear_i) begin
                err_timeout_o <= 1'b0;
            end
            if (zero_len) begin
                err_zero_len_o <= 1'b1;
            end else if (err_clear_i) begin
                err_zero_len_o <= 1'b0;
            end
            if (done_hit && req_q.write && !(&wr_cnt_o)) begin
                wr_cnt_o <= wr_cnt_o + 1'b1;
            end
            if (done_hit && !req_q.write && !(&rd_cnt_o)) begin
                rd_cnt_o <= rd_cnt_o + 1'b1;
            end
        end
    end

    assign busy_o         = (state_q != IDLE);
    assign br_req_valid_o = (state_q == ISSUE);
    assign br_req_write_o = req_q.write;
    assign br_req_addr_o  = ADDR_W'(req_q.addr);
    assign br_req_len_o   = LEN_W'(req_q.len);
    assign br_req_id_o    = ID_W'(req_q.id);
    assign grant_write_o  = busy_o && req_q.write;

endmodule

// File: tb/tb_nvdla_dbb_req_sched.sv
// Directed and randomized bench for nvdla_dbb_req_sched against a
// transaction-level reference model.
module tb_nvdla_dbb_req_sched;

    localparam int TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable_i = 1'b0;
    logic        wr_req_valid_i = 1'b0;
    logic        wr_req_ready_o;
    logic [63:0] wr_req_addr_i = '0;
    logic [3:0]  wr_req_len_i = '0;
    logic [7:0]  wr_req_id_i = '0;
    logic        rd_req_valid_i = 1'b0;
    logic        rd_req_ready_o;
    logic [63:0] rd_req_addr_i = '0;
    logic [3:0]  rd_req_len_i = '0;
    logic [7:0]  rd_req_id_i = '0;
    logic        br_req_valid_o;
    logic        br_req_ready_i = 1'b0;
    logic        br_req_write_o;
    logic [63:0] br_req_addr_o;
    logic [3:0]  br_req_len_o;
    logic [7:0]  br_req_id_o;
    logic        br_done_i = 1'b0;
    logic        grant_write_o;
    logic        busy_o;
    logic        err_timeout_o;
    logic        err_zero_len_o;
    logic        err_clear_i = 1'b0;
    logic [15:0] wr_cnt_o;
    logic [15:0] rd_cnt_o;

    nvdla_dbb_req_sched #(
        .ADDR_W      (64),
        .LEN_W       (4),
        .ID_W        (8),
        .TIMEOUT_CYC (TO),
        .CNT_W       (16)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .wr_req_valid_i (wr_req_valid_i),
        .wr_req_ready_o (wr_req_ready_o),
        .wr_req_addr_i  (wr_req_addr_i),
        .wr_req_len_i   (wr_req_len_i),
        .wr_req_id_i    (wr_req_id_i),
        .rd_req_valid_i (rd_req_valid_i),
        .rd_req_ready_o (rd_req_ready_o),
        .rd_req_addr_i  (rd_req_addr_i),
        .rd_req_len_i   (rd_req_len_i),
        .rd_req_id_i    (rd_req_id_i),
        .br_req_valid_o (br_req_valid_o),
        .br_req_ready_i (br_req_ready_i),
        .br_req_write_o (br_req_write_o),
        .br_req_addr_o  (br_req_addr_o),
        .br_req_len_o   (br_req_len_o),
        .br_req_id_o    (br_req_id_o),
        .br_done_i      (br_done_i),
        .grant_write_o  (grant_write_o),
        .busy_o         (busy_o),
        .err_timeout_o  (err_timeout_o),
        .err_zero_len_o (err_zero_len_o),
        .err_clear_i    (err_clear_i),
        .wr_cnt_o       (wr_cnt_o),
        .rd_cnt_o       (rd_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: arbitration history, expected counters and flags.
    bit m_last_w = 1'b1;
    int exp_wr = 0;
    int exp_rd = 0;
    bit exp_to = 1'b0;
    bit exp_zl = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        wr_req_valid_i = 1'b0;
        rd_req_valid_i = 1'b0;
        br_req_ready_i = 1'b0;
        br_done_i      = 1'b0;
        err_clear_i    = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"}, busy_o, 0);
        chk({tag, ".brv"}, br_req_valid_o, 0);
        chk({tag, ".braddr"}, br_req_addr_o, 0);
        chk({tag, ".brlen"}, br_req_len_o, 0);
        chk({tag, ".brid"}, br_req_id_o, 0);
        chk({tag, ".brw"}, br_req_write_o, 0);
        chk({tag, ".gw"}, grant_write_o, 0);
        chk({tag, ".eto"}, err_timeout_o, 0);
        chk({tag, ".ezl"}, err_zero_len_o, 0);
        chk({tag, ".wcnt"}, wr_cnt_o, 0);
        chk({tag, ".rcnt"}, rd_cnt_o, 0);
        chk({tag, ".wrdy"}, wr_req_ready_o, 0);
        chk({tag, ".rrdy"}, rd_req_ready_o, 0);
    endtask

    task automatic do_reset();
        idle_inputs();
        enable_i = 1'b0;
        rst_i = 1'b1;
        cyc();
        cyc();
        #2;
        chk_all_zero("rst");
        rst_i = 1'b0;
        m_last_w = 1'b1;
        exp_wr = 0;
        exp_rd = 0;
        exp_to = 1'b0;
        exp_zl = 1'b0;
    endtask

    task automatic clr_step(input bit clr, input bit done);
        wr_req_valid_i = 1'b0;
        rd_req_valid_i = 1'b0;
        err_clear_i = clr;
        br_done_i = done;
        cyc();
        err_clear_i = 1'b0;
        br_done_i = 1'b0;
        if (clr) begin
            exp_to = 1'b0;
            exp_zl = 1'b0;
        end
        #2;
        chk("clr.eto", err_timeout_o, exp_to);
        chk("clr.ezl", err_zero_len_o, exp_zl);
        chk("clr.wcnt", wr_cnt_o, exp_wr);
        chk("clr.rcnt", rd_cnt_o, exp_rd);
        chk("clr.busy", busy_o, 0);
    endtask

    // One request presented in IDLE; dd is the WAIT_DONE cycle index carrying
    // br_done_i (dd >= TO means the bridge never completes).
    task automatic txn(input bit wv, input bit rv,
                       input logic [63:0] wa, input logic [63:0] ra,
                       input logic [3:0] wl, input logic [3:0] rl,
                       input logic [7:0] wi, input logic [7:0] ri,
                       input int rdly, input int dd,
                       input bit noise, input bit clr_g);
        bit w;
        logic [63:0] a;
        logic [3:0] l;
        logic [7:0] id;
        int last_k;
        enable_i = 1'b1;
        wr_req_valid_i = wv;
        rd_req_valid_i = rv;
        wr_req_addr_i = wa;
        rd_req_addr_i = ra;
        wr_req_len_i = wl;
        rd_req_len_i = rl;
        wr_req_id_i = wi;
        rd_req_id_i = ri;
        err_clear_i = clr_g;
        w = (wv && rv) ? !m_last_w : wv;
        a = w ? wa : ra;
        l = w ? wl : rl;
        id = w ? wi : ri;
        #2;
        chk("grant.wrdy", wr_req_ready_o, w);
        chk("grant.rrdy", rd_req_ready_o, !w);
        m_last_w = w;
        cyc();
        err_clear_i = 1'b0;
        wr_req_valid_i = 1'b0;
        rd_req_valid_i = 1'b0;
        if (clr_g) begin
            exp_to = 1'b0;
            exp_zl = 1'b0;
        end
        if (l == 4'd0) begin
            exp_zl = 1'b1;
            #2;
            chk("zl.busy", busy_o, 0);
            chk("zl.brv", br_req_valid_o, 0);
            chk("zl.ezl", err_zero_len_o, 1);
            chk("zl.wcnt", wr_cnt_o, exp_wr);
            chk("zl.rcnt", rd_cnt_o, exp_rd);
            return;
        end
        for (int k = 0; k <= rdly; k++) begin
            br_req_ready_i = (k == rdly);
            if (noise) begin
                enable_i = 1'($urandom);
                wr_req_valid_i = 1'($urandom);
                rd_req_valid_i = 1'($urandom);
                br_done_i = 1'($urandom);
            end
            #2;
            chk("iss.brv", br_req_valid_o, 1);
            chk("iss.addr", br_req_addr_o, a);
            chk("iss.len", br_req_len_o, l);
            chk("iss.id", br_req_id_o, id);
            chk("iss.brw", br_req_write_o, w);
            chk("iss.gw", grant_write_o, w);
            chk("iss.wrdy", wr_req_ready_o, 0);
            chk("iss.rrdy", rd_req_ready_o, 0);
            chk("iss.busy", busy_o, 1);
            cyc();
        end
        br_req_ready_i = 1'b0;
        last_k = (dd < TO) ? dd : TO - 1;
        for (int k = 0; k <= last_k; k++) begin
            br_done_i = (k == dd);
            if (noise) begin
                enable_i = 1'($urandom);
                wr_req_valid_i = 1'($urandom);
                rd_req_valid_i = 1'($urandom);
            end
            #2;
            chk("wt.brv", br_req_valid_o, 0);
            chk("wt.gw", grant_write_o, w);
            chk("wt.busy", busy_o, 1);
            chk("wt.eto", err_timeout_o, exp_to);
            chk("wt.wrdy", wr_req_ready_o, 0);
            chk("wt.rrdy", rd_req_ready_o, 0);
            cyc();
        end
        br_done_i = 1'b0;
        wr_req_valid_i = 1'b0;
        rd_req_valid_i = 1'b0;
        enable_i = 1'b1;
        if (dd < TO) begin
            if (w) exp_wr++;
            else exp_rd++;
        end else begin
            exp_to = 1'b1;
        end
        #2;
        chk("end.busy", busy_o, 0);
        chk("end.gw", grant_write_o, 0);
        chk("end.wcnt", wr_cnt_o, exp_wr);
        chk("end.rcnt", rd_cnt_o, exp_rd);
        chk("end.eto", err_timeout_o, exp_to);
        chk("end.ezl", err_zero_len_o, exp_zl);
    endtask

    initial begin
        bit wv, rv;
        int r;

        do_reset();

        // Single read, bridge ready on the 2nd ISSUE cycle, done 6 cycles on.
        txn(0, 1, 64'h0, 64'h1000, 4'd0, 4'd4, 8'h0, 8'h12, 1, 5, 0, 0);

        // Both valid: arbitration alternates starting with read.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            txn(1, 1, 64'hA000 + 64'(i), 64'hB000 + 64'(i), 4'd3, 4'd5,
                8'h40 + 8'(i), 8'h80 + 8'(i), 0, 1, 0, 0);
            chk("rr.order", m_last_w, (i % 2 == 1));
        end
        chk("rr.wcnt", wr_cnt_o, 2);
        chk("rr.rcnt", rd_cnt_o, 2);

        // Zero-length write dropped; clear; then clear racing a new error.
        txn(1, 0, 64'hC0, 64'h0, 4'd0, 4'd0, 8'h5, 8'h0, 0, 0, 0, 0);
        clr_step(1, 0);
        txn(1, 0, 64'hC4, 64'h0, 4'd0, 4'd0, 8'h6, 8'h0, 0, 0, 0, 1);
        clr_step(1, 1);

        // Watchdog expiry, then done on the final allowed cycle.
        txn(0, 1, 64'h0, 64'h2000, 4'd0, 4'd2, 8'h0, 8'h21, 0, TO, 0, 0);
        clr_step(1, 0);
        txn(0, 1, 64'h0, 64'h2040, 4'd0, 4'd2, 8'h0, 8'h22, 0, TO - 1, 0, 0);

        // Disabled with both requests pending.
        do_reset();
        enable_i = 1'b0;
        wr_req_valid_i = 1'b1;
        rd_req_valid_i = 1'b1;
        wr_req_len_i = 4'd1;
        rd_req_len_i = 4'd1;
        for (int i = 0; i < 10; i++) begin
            #2;
            chk("dis.wrdy", wr_req_ready_o, 0);
            chk("dis.rrdy", rd_req_ready_o, 0);
            chk("dis.busy", busy_o, 0);
            cyc();
        end
        txn(1, 1, 64'h3000, 64'h3100, 4'd1, 4'd1, 8'h31, 8'h32, 0, 2, 0, 0);
        chk("dis.first_rd", rd_cnt_o, 1);

        // Reset while waiting for completion.
        do_reset();
        enable_i = 1'b1;
        rd_req_valid_i = 1'b1;
        rd_req_addr_i = 64'h4000;
        rd_req_len_i = 4'd2;
        rd_req_id_i = 8'h44;
        cyc();
        rd_req_valid_i = 1'b0;
        br_req_ready_i = 1'b1;
        cyc();
        br_req_ready_i = 1'b0;
        cyc();
        #2;
        chk("mid.busy", busy_o, 1);
        rst_i = 1'b1;
        cyc();
        #2;
        chk_all_zero("mid");
        rst_i = 1'b0;
        m_last_w = 1'b1;
        br_done_i = 1'b1;
        cyc();
        br_done_i = 1'b0;
        #2;
        chk("mid.rcnt", rd_cnt_o, 0);
        chk("mid.wcnt", wr_cnt_o, 0);
        chk("mid.busy2", busy_o, 0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(1, 3);
            wv = r[1];
            rv = r[0];
            txn(wv, rv, {$urandom, $urandom}, {$urandom, $urandom},
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                8'($urandom), 8'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 9), 1,
                ($urandom_range(0, 7) == 0));
            clr_step(($urandom_range(0, 3) == 0), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
